// File: rtl/cdb_arbiter.sv
// Result broadcast arbiter: per-source FIFOs feeding a round-robin arbiter that
// drives a registered one-result-per-cycle tag/value broadcast bus.
module cdb_arbiter #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DATAW = 32,
  parameter int unsigned TAGW  = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NSRC-1:0]            src_valid,
  input  logic [NSRC*TAGW-1:0]       src_tag,
  input  logic [NSRC*DATAW-1:0]      src_value,
  output logic [NSRC-1:0]            src_ready,
  output logic                       cdb_en,
  output logic [TAGW-1:0]            cdb_tag,
  output logic [DATAW-1:0]           cdb_value,
  output logic [$clog2(NSRC)-1:0]    cdb_src,
  output logic                       busy
);

  localparam int unsigned SW = $clog2(NSRC);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [TAGW-1:0]  r_tag_mem [NSRC][DEPTH];
  logic [DATAW-1:0] r_val_mem [NSRC][DEPTH];
  logic [PW-1:0]    r_wptr    [NSRC];
  logic [PW-1:0]    r_rptr    [NSRC];
  logic [CW-1:0]    r_count   [NSRC];
  logic [SW-1:0]    r_last;

  logic             r_cdb_en;
  logic [TAGW-1:0]  r_cdb_tag;
  logic [DATAW-1:0] r_cdb_value;
  logic [SW-1:0]    r_cdb_src;

  logic [NSRC-1:0]  w_nonempty;
  logic [NSRC-1:0]  w_push;
  logic [NSRC-1:0]  w_pop;
  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_idx;

  // Occupancy flags and source handshake; ready ignores any same-cycle pop.
  always_comb begin
    w_nonempty = '0;
    src_ready  = '0;
    w_push     = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      src_ready[i]  = rst_n & (r_count[i] != CW'(DEPTH));
      w_push[i]     = src_valid[i] & src_ready[i];
    end
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      idx = (32'(r_last) + k) % NSRC;
      if (!w_gnt_vld && w_nonempty[SW'(idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = SW'(idx);
      end
    end
  end

  // Decode the grant into per-source pop strobes.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_pop[i] = w_gnt_vld && (w_gnt_idx == SW'(i));
    end
  end

  // FIFO pointers, occupancy and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSRC); i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_last <= SW'(NSRC - 1);
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
      if (w_gnt_vld) r_last <= w_gnt_idx;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NSRC); i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_wptr[i]] <= src_tag[i*TAGW +: TAGW];
        r_val_mem[i][r_wptr[i]] <= src_value[i*DATAW +: DATAW];
      end
    end
  end

  // Registered broadcast bus; payload holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_en    <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= '0;
    end else if (w_gnt_vld) begin
      r_cdb_en    <= 1'b1;
      r_cdb_tag   <= r_tag_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
      r_cdb_value <= r_val_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
      r_cdb_src   <= w_gnt_idx;
    end else begin
      r_cdb_en <= 1'b0;
    end
  end

  assign cdb_en    = r_cdb_en;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_value = r_cdb_value;
  assign cdb_src   = r_cdb_src;
  assign busy      = |w_nonempty;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int NSRC  = 4;
  localparam int DEPTH = 2;
  localparam int DATAW = 32;
  localparam int TAGW  = 6;
  localparam int SW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC*TAGW-1:0]   src_tag;
  logic [NSRC*DATAW-1:0]  src_value;
  logic [NSRC-1:0]        src_ready;
  logic                   cdb_en;
  logic [TAGW-1:0]        cdb_tag;
  logic [DATAW-1:0]       cdb_value;
  logic [SW-1:0]          cdb_src;
  logic                   busy;

  always #5 clk = ~clk;

  cdb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH), .DATAW(DATAW), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_value (src_value),
    .src_ready (src_ready),
    .cdb_en    (cdb_en),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one queue of {tag,value} per source plus the expected bus.
  logic [TAGW+DATAW-1:0] q [NSRC][$];
  int                    last_g;
  bit                    exp_en;
  logic [TAGW-1:0]       exp_tag;
  logic [DATAW-1:0]      exp_val;
  int                    exp_src;
  bit                    accepted [NSRC];

  // Observation hooks for the fairness and backpressure scenarios.
  bit              fair_on = 0;
  int              fair_n = 0;
  int              fair_rep = 0;
  int              fair_prev = -1;
  int              fair_cnt [NSRC];
  bit              bp_on = 0;
  bit              bp_low = 0;
  logic [TAGW-1:0] bp_seen [$];

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      q[i].delete();
      accepted[i] = 0;
    end
    last_g  = NSRC - 1;
    exp_en  = 0;
    exp_tag = '0;
    exp_val = '0;
    exp_src = 0;
  endtask

  // Runs at the falling edge: compare outputs, then advance the model across the next rise.
  task automatic step();
    bit any;
    int g;
    logic [TAGW+DATAW-1:0] e;
    check("cdb_en", {63'd0, cdb_en}, {63'd0, exp_en});
    if (exp_en) begin
      check("cdb_tag", 64'(cdb_tag), 64'(exp_tag));
      check("cdb_value", 64'(cdb_value), 64'(exp_val));
      check("cdb_src", 64'(cdb_src), 64'(exp_src));
    end
    any = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (q[i].size() > 0) any = 1;
      check($sformatf("src_ready[%0d]", i), {63'd0, src_ready[i]},
            {63'd0, (q[i].size() < DEPTH)});
    end
    check("busy", {63'd0, busy}, {63'd0, any});

    if (fair_on && cdb_en && fair_n < 40) begin
      if (int'(cdb_src) == fair_prev) fair_rep++;
      fair_cnt[cdb_src]++;
      fair_prev = int'(cdb_src);
      fair_n++;
    end
    if (bp_on) begin
      if (!src_ready[2]) bp_low = 1;
      if (cdb_en && cdb_src == 2'd2) bp_seen.push_back(cdb_tag);
    end

    for (int i = 0; i < NSRC; i++) accepted[i] = src_valid[i] && (q[i].size() < DEPTH);
    g = -1;
    for (int k = 1; k <= NSRC; k++) begin
      int idx;
      idx = (last_g + k) % NSRC;
      if (g < 0 && q[idx].size() > 0) g = idx;
    end
    if (g >= 0) begin
      e = q[g].pop_front();
      {exp_tag, exp_val} = e;
      exp_en  = 1;
      exp_src = g;
      last_g  = g;
    end else begin
      exp_en = 0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (accepted[i]) q[i].push_back({src_tag[i*TAGW +: TAGW], src_value[i*DATAW +: DATAW]});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  // New offer only once the previous one was taken; mode 0 idle, 1 always, 2 random.
  task automatic drive(input int mode, input int pct);
    for (int i = 0; i < NSRC; i++) begin
      if (!src_valid[i] || accepted[i]) begin
        if (mode == 0)      src_valid[i] = 1'b0;
        else if (mode == 1) src_valid[i] = 1'b1;
        else                src_valid[i] = ($urandom_range(99) < pct);
        src_tag[i*TAGW +: TAGW]    = TAGW'($urandom);
        src_value[i*DATAW +: DATAW] = $urandom;
      end
    end
  endtask

  initial begin
    logic [TAGW-1:0] bp_tags [3];
    int bp_idx;
    bp_tags = '{6'd10, 6'd11, 6'd12};
    src_valid = '0;
    src_tag   = '0;
    src_value = '0;
    for (int i = 0; i < NSRC; i++) fair_cnt[i] = 0;
    model_reset();

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst src_ready", 64'(src_ready), 64'd0);
    check("rst cdb_en", {63'd0, cdb_en}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst cdb_value", 64'(cdb_value), 64'd0);
    check("rst cdb_src", 64'(cdb_src), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single result from source 0
    src_valid[0] = 1'b1;
    src_tag[0 +: TAGW] = 6'h05;
    src_value[0 +: DATAW] = 32'hDEADBEEF;
    cyc();
    src_valid[0] = 1'b0;
    repeat (3) cyc();

    // All sources at once
    for (int i = 0; i < NSRC; i++) begin
      src_valid[i] = 1'b1;
      src_tag[i*TAGW +: TAGW] = TAGW'(i + 1);
      src_value[i*DATAW +: DATAW] = $urandom;
    end
    cyc();
    src_valid = '0;
    repeat (6) cyc();

    // Backpressure on source 2 while sources 0 and 1 keep their FIFOs loaded
    bp_on  = 1;
    bp_idx = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!src_valid[i] || accepted[i]) begin
          src_valid[i] = 1'b1;
          src_tag[i*TAGW +: TAGW] = TAGW'($urandom);
          src_value[i*DATAW +: DATAW] = $urandom;
        end
      end
      if (!src_valid[2] || accepted[2]) begin
        if (bp_idx < 3) begin
          src_valid[2] = 1'b1;
          src_tag[2*TAGW +: TAGW] = bp_tags[bp_idx];
          src_value[2*DATAW +: DATAW] = $urandom;
          bp_idx++;
        end else begin
          src_valid[2] = 1'b0;
        end
      end
      src_valid[3] = 1'b0;
      cyc();
    end
    src_valid = '0;
    repeat (12) cyc();
    bp_on = 0;
    check("bp ready2 fell", {63'd0, bp_low}, 64'd1);
    check("bp src2 count", 64'(bp_seen.size()), 64'd3);
    for (int k = 0; k < 3 && k < bp_seen.size(); k++) begin
      check($sformatf("bp src2 order[%0d]", k), 64'(bp_seen[k]), 64'(bp_tags[k]));
    end

    // Fairness with every source valid every cycle
    fair_on = 1;
    for (int c = 0; c < 46; c++) begin
      drive(1, 0);
      cyc();
    end
    fair_on = 0;
    src_valid = '0;
    repeat (12) cyc();
    check("fair broadcasts", 64'(fair_n), 64'd40);
    check("fair repeats", 64'(fair_rep), 64'd0);
    for (int i = 0; i < NSRC; i++) begin
      check($sformatf("fair count[%0d]", i), 64'(fair_cnt[i]), 64'd10);
    end

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      drive(2, (c < 150) ? 40 : 85);
      cyc();
    end

    // Asynchronous reset with entries buffered
    for (int c = 0; c < 3; c++) begin
      drive(1, 0);
      cyc();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async cdb_en", {63'd0, cdb_en}, 64'd0);
    check("async busy", {63'd0, busy}, 64'd0);
    check("async src_ready", 64'(src_ready), 64'd0);
    src_valid = '0;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc();
    for (int c = 0; c < 100; c++) begin
      drive(2, 60);
      cyc();
    end
    src_valid = '0;
    repeat (12) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
